regfile_param: RTL and testbench

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/regfile_wdata_ext.sv | 66 ++++++
 rtl/regfile_param.sv | 130 +++++++++++++
 tb/tb_regfile_param.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared encodings for the parameterised register file: write modes, FSM states
// and the lane widths used by the write-value extension.
package regfile_pkg;

   localparam logic [2:0] WM_WORD = 3'd0;
   localparam logic [2:0] WM_LB   = 3'd1;
   localparam logic [2:0] WM_LBU  = 3'd2;
   localparam logic [2:0] WM_LH   = 3'd3;
   localparam logic [2:0] WM_LHU  = 3'd4;
   localparam logic [2:0] WM_LINK = 3'd5;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   localparam int BYTE_W   = 8;
   localparam int HALF_W   = 16;
   localparam int LINK_INC = 4;

endpackage

// File: rtl/regfile_wdata_ext.sv
// Write-value extension: selects and sign/zero-extends the byte or halfword,
// builds the link value, and flags suppressed or misaligned writes.
module wdata_ext
   import regfile_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      i_wmode,
   input  logic [XLEN-1:0] i_wdata,
   input  logic [1:0]      i_boff,
   input  logic [XLEN-1:0] i_pc,
   output logic [XLEN-1:0] o_val,
   output logic            o_suppress,
   output logic            o_misalign,
   output logic            o_link
);

   logic [BYTE_W-1:0] w_byte;
   logic [HALF_W-1:0] w_half;

   // Byte and halfword lane selection from the low 32 bits.
   always_comb begin
      w_byte = i_wdata[7:0];
      case (i_boff)
         2'd0:    w_byte = i_wdata[7:0];
         2'd1:    w_byte = i_wdata[15:8];
         2'd2:    w_byte = i_wdata[23:16];
         2'd3:    w_byte = i_wdata[31:24];
         default: w_byte = i_wdata[7:0];
      endcase
      if (i_boff[1]) begin
         w_half = i_wdata[31:16];
      end else begin
         w_half = i_wdata[15:0];
      end
   end

   // Mode decode; unknown modes and odd halfword offsets never write.
   always_comb begin
      o_val      = '0;
      o_suppress = 1'b0;
      o_misalign = 1'b0;
      o_link     = 1'b0;
      case (i_wmode)
         WM_WORD: o_val = i_wdata;
         WM_LB:   o_val = {{(XLEN-BYTE_W){w_byte[BYTE_W-1]}}, w_byte};
         WM_LBU:  o_val = {{(XLEN-BYTE_W){1'b0}}, w_byte};
         WM_LH, WM_LHU: begin
            if (i_boff[0]) begin
               o_suppress = 1'b1;
               o_misalign = 1'b1;
            end else if (i_wmode == WM_LH) begin
               o_val = {{(XLEN-HALF_W){w_half[HALF_W-1]}}, w_half};
            end else begin
               o_val = {{(XLEN-HALF_W){1'b0}}, w_half};
            end
         end
         WM_LINK: begin
            o_val  = i_pc + XLEN'(LINK_INC);
            o_link = 1'b1;
         end
         default: o_suppress = 1'b1;
      endcase
   end

endmodule

// File: rtl/regfile_param.sv
// Parameterised register file with load-extension write path, optional write
// forwarding and a sequential clear FSM instead of a storage reset.
module regfile_param
   import regfile_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int NREG   = 32,
   parameter int BYPASS = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    we,
   input  logic [2:0]              wmode,
   input  logic [$clog2(NREG)-1:0] waddr,
   input  logic [XLEN-1:0]         wdata,
   input  logic [1:0]              boff,
   input  logic [XLEN-1:0]         pc,
   input  logic [$clog2(NREG)-1:0] ra,
   input  logic [$clog2(NREG)-1:0] rb,
   output logic [XLEN-1:0]         busa,
   output logic [XLEN-1:0]         busb,
   output logic                    ready,
   output logic                    misalign
);

   localparam int AW = $clog2(NREG);
   localparam logic [AW-1:0] CNT_FIRST = AW'(1);
   localparam logic [AW-1:0] CNT_LAST  = AW'(NREG - 1);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [AW-1:0]   r_cnt;
   logic [AW-1:0]   w_cnt_nxt;
   logic            r_misalign;
   logic [XLEN-1:0] r_mem [NREG];

   logic [XLEN-1:0] w_ext_val;
   logic            w_suppress;
   logic            w_mis;
   logic            w_link;
   logic [AW-1:0]   w_target;
   logic            w_wr;
   logic            w_fwd;
   logic            w_byp_a;
   logic            w_byp_b;

   wdata_ext #(.XLEN(XLEN)) u_ext (
      .i_wmode    (wmode),
      .i_wdata    (wdata),
      .i_boff     (boff),
      .i_pc       (pc),
      .o_val      (w_ext_val),
      .o_suppress (w_suppress),
      .o_misalign (w_mis),
      .o_link     (w_link)
   );

   assign ready    = (r_state == ST_RUN);
   assign misalign = r_misalign;
   assign w_target = w_link ? CNT_LAST : waddr;
   assign w_wr     = ready & we & ~clr & ~w_suppress & (w_target != '0);
   assign w_fwd    = (BYPASS != 0) & ready & we & ~w_suppress;
   assign w_byp_a  = w_fwd & (ra == w_target) & (ra != '0);
   assign w_byp_b  = w_fwd & (rb == w_target) & (rb != '0);

   // Clear-sequence next state; clr restarts from register 1 in any state.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (clr) begin
         w_state_nxt = ST_CLEAR;
         w_cnt_nxt   = CNT_FIRST;
      end else begin
         case (r_state)
            ST_CLEAR: begin
               if (r_cnt == CNT_LAST) begin
                  w_state_nxt = ST_RUN;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_FIRST;
               end
            end
            ST_RUN: w_state_nxt = ST_RUN;
            default: begin
               w_state_nxt = ST_CLEAR;
               w_cnt_nxt   = CNT_FIRST;
            end
         endcase
      end
   end

   // FSM, counter and misalign pulse registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_CLEAR;
         r_cnt      <= CNT_FIRST;
         r_misalign <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_misalign <= w_mis & ready & we & ~clr;
      end
   end

   // Storage without reset so it can map onto distributed RAM.
   always_ff @(posedge clk) begin
      if (r_state == ST_CLEAR) begin
         r_mem[r_cnt] <= '0;
      end else if (w_wr) begin
         r_mem[w_target] <= w_ext_val;
      end
   end

   // Read ports with register-0 and not-ready masking plus forwarding.
   always_comb begin
      busa = '0;
      busb = '0;
      if (ready && (ra != '0)) begin
         busa = w_byp_a ? w_ext_val : r_mem[ra];
      end else begin
         busa = '0;
      end
      if (ready && (rb != '0)) begin
         busb = w_byp_b ? w_ext_val : r_mem[rb];
      end else begin
         busb = '0;
      end
   end

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param: stimulus queues expected values, a
// negedge monitor pops and compares them against BYPASS=1 and BYPASS=0 copies.
module tb_regfile_param;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = 5;

   localparam logic [2:0] M_WORD = 3'd0;
   localparam logic [2:0] M_LB   = 3'd1;
   localparam logic [2:0] M_LBU  = 3'd2;
   localparam logic [2:0] M_LH   = 3'd3;
   localparam logic [2:0] M_LHU  = 3'd4;
   localparam logic [2:0] M_LINK = 3'd5;

   localparam int S_A1 = 0, S_B1 = 1, S_RDY1 = 2, S_MIS1 = 3;
   localparam int S_A0 = 4, S_RDY0 = 5, S_MIS0 = 6, S_B0 = 7;

   logic            clk = 1'b0;
   logic            rst, clr, we;
   logic [2:0]      wmode;
   logic [AW-1:0]   waddr, ra, rb;
   logic [XLEN-1:0] wdata, pc;
   logic [1:0]      boff;
   logic [XLEN-1:0] busa1, busb1, busa0, busb0;
   logic            ready1, ready0, mis1, mis0;

   typedef struct {
      string           nm;
      int              sel;
      logic [XLEN-1:0] v;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   regfile_param #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1)) u_dut1 (
      .clk(clk), .rst(rst), .clr(clr), .we(we), .wmode(wmode), .waddr(waddr),
      .wdata(wdata), .boff(boff), .pc(pc), .ra(ra), .rb(rb),
      .busa(busa1), .busb(busb1), .ready(ready1), .misalign(mis1)
   );

   regfile_param #(.XLEN(XLEN), .NREG(NREG), .BYPASS(0)) u_dut0 (
      .clk(clk), .rst(rst), .clr(clr), .we(we), .wmode(wmode), .waddr(waddr),
      .wdata(wdata), .boff(boff), .pc(pc), .ra(ra), .rb(rb),
      .busa(busa0), .busb(busb0), .ready(ready0), .misalign(mis0)
   );

   function automatic void expect_v(input string nm, input int sel, input logic [XLEN-1:0] v);
      exp_t e;
      e.nm  = nm;
      e.sel = sel;
      e.v   = v;
      sb.push_back(e);
   endfunction

   // Monitor: every queued expectation is checked at the next falling edge.
   always @(negedge clk) begin
      exp_t e;
      logic [XLEN-1:0] act;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.sel)
            S_A1:    act = busa1;
            S_B1:    act = busb1;
            S_RDY1:  act = {31'd0, ready1};
            S_MIS1:  act = {31'd0, mis1};
            S_A0:    act = busa0;
            S_RDY0:  act = {31'd0, ready0};
            S_MIS0:  act = {31'd0, mis0};
            S_B0:    act = busb0;
            default: act = 32'hxxxx_xxxx;
         endcase
         n_tests++;
         if (act !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.nm, act, e.v);
         end
      end
   end

   // Watchdog: flags a hung sequence that never completes.
   initial begin
      #200000;
      n_tests++;
      n_fail++;
      $display("FAIL timeout: stimulus did not complete in time");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] m, input logic [AW-1:0] a, input logic [XLEN-1:0] d,
                     input logic [1:0] bo, input logic [XLEN-1:0] p);
      wmode = m; waddr = a; wdata = d; boff = bo; pc = p; we = 1'b1;
      tick();
      we = 1'b0;
   endtask

   task automatic rd(input string nm, input logic [AW-1:0] a, input logic [XLEN-1:0] v);
      ra = a; rb = a;
      expect_v(nm, S_A1, v);
      expect_v(nm, S_B1, v);
      expect_v(nm, S_A0, v);
      tick();
   endtask

   // Expects NREG-1 not-ready cycles; optionally pokes writes that must be dropped.
   task automatic chk_clear(input string nm, input bit extra);
      ra = 5'd5; rb = 5'd31;
      for (int i = 0; i < NREG - 1; i++) begin
         expect_v({nm, "_rdy0"}, S_RDY1, 32'd0);
         expect_v({nm, "_rdy0b"}, S_RDY0, 32'd0);
         expect_v({nm, "_rd0"}, S_A1, 32'd0);
         if (extra && i == 3) begin
            wmode = M_LHU; waddr = 5'd4; boff = 2'd1; wdata = 32'h1234_5678; we = 1'b1;
         end else if (extra && i == 4) begin
            expect_v("mis_in_clear", S_MIS1, 32'd0);
            wmode = M_WORD; waddr = 5'd2; boff = 2'd0; wdata = 32'h5555_AAAA; we = 1'b1;
         end else begin
            we = 1'b0;
         end
         tick();
      end
      we = 1'b0;
      expect_v({nm, "_rdy1"}, S_RDY1, 32'd1);
      expect_v({nm, "_rdy1b"}, S_RDY0, 32'd1);
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; we = 1'b0; wmode = M_WORD; waddr = '0;
      wdata = '0; boff = '0; pc = '0; ra = '0; rb = '0;
      tick(); tick();
      n_tests++;
      if (ready1 !== 1'b0 || mis1 !== 1'b0 || ready0 !== 1'b0 || mis0 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: ready1=%b mis1=%b ready0=%b mis0=%b",
                  ready1, mis1, ready0, mis0);
      end
      expect_v("rst_ready", S_RDY1, 32'd0);
      expect_v("rst_mis", S_MIS1, 32'd0);
      tick();
      rst = 1'b0;
      chk_clear("init", 1'b0);
      for (int i = 0; i < NREG; i += 2) begin
         ra = AW'(i); rb = AW'(i + 1);
         expect_v("init_zero_a", S_A1, 32'd0);
         expect_v("init_zero_b", S_B1, 32'd0);
         tick();
      end

      wr(M_WORD, 5'd5, 32'h80FF_7F01, 2'd0, 32'd0);
      rd("word_r5", 5'd5, 32'h80FF_7F01);
      wr(M_LB, 5'd6, 32'h1280_3456, 2'd2, 32'd0);
      rd("lb_r6", 5'd6, 32'hFFFF_FF80);
      wr(M_LBU, 5'd6, 32'h1280_3456, 2'd2, 32'd0);
      rd("lbu_r6", 5'd6, 32'h0000_0080);
      wr(M_LH, 5'd8, 32'h8001_0000, 2'd2, 32'd0);
      rd("lh_r8", 5'd8, 32'hFFFF_8001);
      wr(M_LHU, 5'd11, 32'h0000_ABCD, 2'd0, 32'd0);
      rd("lhu_r11", 5'd11, 32'h0000_ABCD);

      wmode = M_LHU; waddr = 5'd8; wdata = 32'h1234_5678; boff = 2'd1; we = 1'b1;
      expect_v("mis_pre", S_MIS1, 32'd0);
      tick();
      we = 1'b0;
      expect_v("mis_pulse1", S_MIS1, 32'd1);
      expect_v("mis_pulse0", S_MIS0, 32'd1);
      tick();
      expect_v("mis_end", S_MIS1, 32'd0);
      rd("lhu_miss_r8", 5'd8, 32'hFFFF_8001);

      wr(M_LINK, 5'd3, 32'hFFFF_FFFF, 2'd0, 32'h0040_0010);
      rd("link_r31", 5'd31, 32'h0040_0014);
      rd("link_r3", 5'd3, 32'd0);
      wr(M_WORD, 5'd0, 32'h1234_5678, 2'd0, 32'd0);
      rd("word_r0", 5'd0, 32'd0);
      wr(3'd6, 5'd9, 32'hFFFF_FFFF, 2'd0, 32'd0);
      wr(3'd7, 5'd9, 32'hFFFF_FFFF, 2'd0, 32'd0);
      rd("resv_r9", 5'd9, 32'd0);

      ra = 5'd7; rb = 5'd8;
      wmode = M_WORD; waddr = 5'd7; wdata = 32'hDEAD_BEEF; boff = 2'd0; we = 1'b1;
      expect_v("byp_a1", S_A1, 32'hDEAD_BEEF);
      expect_v("byp_a0", S_A0, 32'd0);
      expect_v("byp_b_other", S_B1, 32'hFFFF_8001);
      tick();
      we = 1'b0;
      rd("byp_r7", 5'd7, 32'hDEAD_BEEF);

      ra = 5'd8; rb = 5'd10;
      wmode = M_LH; waddr = 5'd8; wdata = 32'h0000_0000; boff = 2'd1; we = 1'b1;
      expect_v("byp_suppr", S_A1, 32'hFFFF_8001);
      tick();
      wmode = M_LB; waddr = 5'd10; wdata = 32'h7F00_0000; boff = 2'd3;
      expect_v("byp_lb_b1", S_B1, 32'h0000_007F);
      expect_v("byp_lb_b0", S_B0, 32'd0);
      tick();
      we = 1'b0;
      rd("lb_r10", 5'd10, 32'h0000_007F);

      ra = 5'd5; rb = 5'd12;
      clr = 1'b1; wmode = M_WORD; waddr = 5'd12; wdata = 32'hAAAA_5555; we = 1'b1;
      expect_v("clr_cycle_rdy", S_RDY1, 32'd1);
      expect_v("clr_cycle_r5", S_A1, 32'h80FF_7F01);
      tick();
      clr = 1'b0; we = 1'b0;
      chk_clear("clr", 1'b1);
      for (int i = 0; i < NREG; i += 2) begin
         ra = AW'(i); rb = AW'(i + 1);
         expect_v("clr_zero_a", S_A1, 32'd0);
         expect_v("clr_zero_b", S_B1, 32'd0);
         tick();
      end

      wr(M_WORD, 5'd5, 32'h0BAD_F00D, 2'd0, 32'd0);
      rd("pre_rst_r5", 5'd5, 32'h0BAD_F00D);
      #2;
      rst = 1'b1;
      #1;
      expect_v("async_rst_rdy", S_RDY1, 32'd0);
      tick();
      rst = 1'b0;
      chk_clear("rst_run", 1'b0);
      rd("post_rst_r5", 5'd5, 32'd0);

      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
